// File: rtl/serial_tx_reg.sv
// Parallel-in / serial-out transmitter: captures PI on ld, shifts it out LSB first, pulses done.
// Optional even-parity bit after the data bits when SERIAL_TX_PARITY_EN is defined.
module serial_tx_reg #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] PI,
  output logic             so,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef SERIAL_TX_PARITY_EN
    S_PAR   = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_TX_PARITY_EN
  logic             acc_q, acc_d;
`endif

  // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_TX_PARITY_EN
    acc_d   = acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ld) begin
          state_d = S_SHIFT;
          sr_d    = PI;
          cnt_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
          acc_d   = 1'b0;
`endif
        end
      end

      S_SHIFT: begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
`ifdef SERIAL_TX_PARITY_EN
        acc_d = acc_q ^ sr_q[0];
`endif
        if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
          // The parity cycle reports cnt=WIDTH; the wrap to 0 happens on entering DONE.
          state_d = S_PAR;
          cnt_d   = CW'(WIDTH);
`else
          state_d = S_DONE;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      S_PAR: begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end
    endcase

    // Abort wins over anything the state decode chose, including a new ld.
    if (clr) begin
      state_d = S_IDLE;
      sr_d    = '0;
      cnt_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
      acc_d   = 1'b0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_TX_PARITY_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Outputs decode registered state only, so ld/clr have no combinational path to them.
  always_comb begin
    so = 1'b0;
    case (state_q)
      S_SHIFT: so = sr_q[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PAR:   so = acc_q;
`endif
      default: so = 1'b0;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign cnt  = cnt_q;

  a_done_one_cycle : assert property (@(posedge clk) disable iff (rst)
    (state_q == S_DONE) |=> (state_q == S_IDLE));

  a_cnt_range : assert property (@(posedge clk) disable iff (rst)
    (cnt_q <= CW'(WIDTH)));

endmodule
